fir_mac_ctrl: RTL

Sequencing controller for the FIR multiply-accumulate datapath. It accepts one input sample per filter evaluation and writes it into the circular sample buffer. It then walks TAPS coefficient/sample address pairs through the multiplier into the adder/accumulator, with accumulator enables aligned to the multiplier latency, and presents the finished sum with a valid/ready handshake. It sits between the sample source and the multiplier → adder (`mnozenie_wynik + Acc_out → suma_wynik`) → accumulator register path; it carries no data itself.

---
 rtl/fir_mac_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_ctrl.sv
// -----------------------------------------------------------------------------
// fir_mac_ctrl
//
// Sequencing controller for an FIR multiply-accumulate datapath. It accepts one
// sample per filter evaluation and writes it into the circular sample buffer at
// the write pointer. It then walks TAPS sample/coefficient address pairs into
// the multiplier, newest sample first. Accumulator load enables are aligned to
// the multiplier latency. The finished sum is presented with a valid/ready
// handshake. No data passes through this block.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   probka_valid   in : new sample offered
//   probka_ready   out: sample can be accepted (IDLE only)
//   wr_en          out: sample buffer write strobe (accept cycle)
//   wr_addr        out: sample buffer write address (accept cycle, else 0)
//   rd_addr        out: sample buffer read address, multiplier operand A
//   coef_addr      out: coefficient address, multiplier operand B
//   acc_clr        out: clear accumulator (accept cycle)
//   acc_en         out: accumulator load, MAC issue delayed by MUL_LAT
//   wynik_valid    out: accumulator holds a finished output (DONE)
//   wynik_ready    in : consumer takes the output
//   busy           out: state is not IDLE
// -----------------------------------------------------------------------------
module fir_mac_ctrl #(
    parameter int TAPS    = 16,
    parameter int ADDR_W  = 4,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              probka_valid,
    output logic              probka_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              wynik_valid,
    input  logic              wynik_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(TAPS - 1);
    // TAPS may equal 2^ADDR_W, in which case this truncates to 0. The wrapped
    // read address is still correct because the sum is taken modulo 2^ADDR_W.
    localparam logic [ADDR_W-1:0] TAPS_LOW   = ADDR_W'(TAPS);
    localparam logic [2:0]        DRAIN_LAST = 3'((MUL_LAT > 0) ? (MUL_LAT - 1) : 0);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_p;
    logic [ADDR_W-1:0] r_k;
    logic [2:0]        r_drain;
    logic              w_issue;
    logic              w_acc_en_dly;
    logic [ADDR_W-1:0] w_rd;

    assign w_issue = (r_state == S_MAC);

    // MAC-issue delay line that produces the accumulator enable
    generate
        if (MUL_LAT == 0) begin : g_no_lat
            assign w_acc_en_dly = w_issue;
        end else begin : g_lat
            logic [MUL_LAT-1:0] r_dly;

            // Shift register: one stage per multiplier pipeline register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= (r_dly << 1) | MUL_LAT'(w_issue);
                end
            end

            assign w_acc_en_dly = r_dly[MUL_LAT-1];
        end
    endgenerate

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (probka_valid) begin
                    w_next_state = S_MAC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MAC: begin
                if (r_k == LAST_IDX) begin
                    w_next_state = (MUL_LAT > 0) ? S_DRAIN : S_DONE;
                end else begin
                    w_next_state = S_MAC;
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DONE: begin
                if (wynik_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Tap counter: zero in IDLE, steps through MAC, then parks on the last tap
    // so the addresses hold through DRAIN and DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k <= '0;
        end else if (r_state == S_IDLE) begin
            r_k <= '0;
        end else if ((r_state == S_MAC) && (r_k != LAST_IDX)) begin
            r_k <= r_k + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            r_k <= r_k;
        end
    end

    // Drain counter: counts multiplier-latency cycles after the last issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain <= 3'd0;
        end else if (r_state == S_DRAIN) begin
            r_drain <= r_drain + 3'd1;
        end else begin
            r_drain <= 3'd0;
        end
    end

    // Write pointer: advances once per completed output handshake, modulo TAPS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if ((r_state == S_DONE) && wynik_ready) begin
            r_p <= (r_p == LAST_IDX) ? '0 : (r_p + {{(ADDR_W-1){1'b0}}, 1'b1});
        end else begin
            r_p <= r_p;
        end
    end

    // Read address: newest sample first, wrapping modulo TAPS
    always_comb begin
        w_rd = '0;
        if (r_p >= r_k) begin
            w_rd = r_p - r_k;
        end else begin
            w_rd = r_p - r_k + TAPS_LOW;
        end
    end

    // Output decode: everything is forced to 0 while reset is asserted
    always_comb begin
        probka_ready = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        rd_addr      = '0;
        coef_addr    = '0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        wynik_valid  = 1'b0;
        busy         = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    probka_ready = 1'b1;
                    if (probka_valid) begin
                        wr_en   = 1'b1;
                        wr_addr = r_p;
                        acc_clr = 1'b1;
                    end else begin
                        wr_en   = 1'b0;
                    end
                end
                S_MAC, S_DRAIN: begin
                    busy      = 1'b1;
                    rd_addr   = w_rd;
                    coef_addr = r_k;
                    acc_en    = w_acc_en_dly;
                end
                S_DONE: begin
                    busy        = 1'b1;
                    rd_addr     = w_rd;
                    coef_addr   = r_k;
                    wynik_valid = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

endmodule
